latch_write_arbiter: RTL and testbench
======================================

# latch_write_arbiter

- Sequences write cycles into a shared bank of `WIDTH` NOR-based gated D latches: one `En` input driven in common, one `D` bit and one `Q`/`not_Q` pair per latch.
- Serves `NREQ` requesters through round-robin arbitration.
- Each write follows a fixed setup → enable → hold timing discipline, so `D` is never changed while `En` is high, then reads back `Q`/`not_Q` to confirm the latch captured the data.
- Sits between clocked requester logic and the asynchronous latch bank. It is the only block permitted to drive the bank's `En` and `D`.

## Interface
Parameters:
- `WIDTH`, 8: latch bank width.
- `NREQ`, 4: number of requesters, 2..8.
- `SETUP_CYCLES`, 1: cycles `D` is stable with `En`=0 before enable; ≥1.
- `EN_CYCLES`, 2: cycles `En` is held high; ≥1.
- `HOLD_CYCLES`, 1: cycles `D` is held after `En` falls; ≥1.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: write request per requester; held high until `ack`.
- `data_in` in NREQ*WIDTH: requester i's data at bits [i*WIDTH +: WIDTH]; held stable while `req[i]` is high.
- `ack` out NREQ: one-cycle completion pulse to the granted requester.
- `latch_en` out 1: drives `En` of every latch in the bank.
- `latch_d` out WIDTH: drives `D` of the bank.
- `latch_q` in WIDTH: bank `Q`.
- `latch_nq` in WIDTH: bank `not_Q`.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out clog2(NREQ): index of the current or last granted requester.
- `err` out 1: one-cycle pulse with `ack` when readback fails.
- `err_sticky` out 1: set on any `err`; cleared only by `rst`.

## Operation
- FSM states: IDLE → SETUP → ENABLE → HOLD → CHECK → IDLE.
- **IDLE:** if any `req` is high at the edge, grant the first requester with `req` high, searching from `rr_ptr` upward modulo NREQ.
  - On that edge: load `latch_d` from that requester's `data_in`, register `grant_id`, zero the phase counter, go to SETUP.
- **SETUP:** `latch_en`=0, `latch_d` held. Stay SETUP_CYCLES cycles, then go to ENABLE.
- **ENABLE:** `latch_en`=1 (registered output, glitch-free), `latch_d` held. Stay EN_CYCLES cycles, then go to HOLD.
- **HOLD:** `latch_en`=0, `latch_d` held. Stay HOLD_CYCLES cycles, then go to CHECK.
- **CHECK** (exactly 1 cycle):
  - `ack[grant_id]`=1.
  - Compare: `err`=1 if `latch_q`≠`latch_d` or `latch_nq`≠~`latch_d`; `err_sticky` set accordingly.
  - `rr_ptr` ← `grant_id`+1 mod NREQ.
  - Go to IDLE.
- `latch_d` retains its value after CHECK and through IDLE, so latch inputs do not toggle needlessly. It changes only at a grant or at reset.
- `req`/`data_in` changes on non-granted requesters during a write are ignored. They are evaluated at the next IDLE.
- A requester whose `req` stays high after `ack` is treated as a new request. Round-robin order still places it last.
- Reset values:
  - state=IDLE
  - `latch_en`=0, `latch_d`=0, `ack`=0
  - `busy`=0, `grant_id`=0
  - `err`=0, `err_sticky`=0
  - `rr_ptr`=0
- Reset mid-write: on the reset edge, `latch_en` drops to 0 and the write is abandoned with no `ack`. Bank contents are then unspecified.

## Timing
- Let the grant edge be k. Then:
  - SETUP occupies cycles k+1 .. k+SETUP_CYCLES.
  - `latch_en` is high for exactly EN_CYCLES cycles, starting at k+SETUP_CYCLES+1.
  - `ack` is high in cycle k+SETUP_CYCLES+EN_CYCLES+HOLD_CYCLES+1.
  - Defaults: `ack` at k+5.
- Throughput with back-to-back requests: one write per SETUP_CYCLES+EN_CYCLES+HOLD_CYCLES+2 cycles (6 at defaults), including one IDLE bubble.
- `latch_d` never changes while `latch_en`=1, or in the cycles adjacent to it.
- `latch_q`/`latch_nq` must settle within one clock after `latch_en` rises. They are sampled only in CHECK.
- `busy` is high from k+1 through the CHECK cycle inclusive.

## Test plan
- Single write: `rst` then release; `req[2]`=1, `data_in` slice 2 = 8'hA5 → `grant_id`=2, `latch_en` high exactly 2 cycles, `latch_d`=A5 throughout, `ack[2]` at k+5, `err`=0.
- Round-robin: `req`=4'b1111 held, each requester dropping its request after its `ack` and re-raising it → grants in order 0,1,2,3,0 with 6 cycles between acks; no requester is granted twice before all others are served.
- Readback fault: force `latch_q`=8'h00 while writing 8'hFF → `err` pulses with `ack`; `err_sticky`=1 and stays 1 across later passing writes until `rst`.
- `not_Q` fault: `latch_nq` stuck equal to `latch_q` → `err`=1 in CHECK.
- Reset mid-write: assert `rst` during ENABLE → next cycle `latch_en`=0, `busy`=0, `latch_d`=0, no `ack`; a subsequent `req[1]` is granted (`rr_ptr`=0 after reset).
- `data_in[0]` toggled during ENABLE after a grant to requester 0 → `latch_d` unchanged; readback matches the originally sampled value.

Source files
------------

// File: rtl/latch_write_arbiter.sv
// Round-robin write sequencer for a bank of NOR gated D latches.
// Each grant runs setup -> enable -> hold on the shared En, then verifies Q/not_Q.
module latch_write_arbiter #(
  parameter int WIDTH        = 8,
  parameter int NREQ         = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    data_in,
  output logic [NREQ-1:0]          ack,
  output logic                     latch_en,
  output logic [WIDTH-1:0]         latch_d,
  input  logic [WIDTH-1:0]         latch_q,
  input  logic [WIDTH-1:0]         latch_nq,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     err,
  output logic                     err_sticky
);

  localparam int IDW  = $clog2(NREQ);
  localparam int MAX1 = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAXC = (MAX1 > HOLD_CYCLES) ? MAX1 : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]  SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0]  EN_LAST    = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0]  HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [IDW-1:0] ID_LAST    = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_W     = (IDW+1)'(NREQ);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ENABLE = 3'd2,
    HOLD   = 3'd3,
    CHECK  = 3'd4
  } state_t;

  // True when the bank did not capture d on both the Q and not_Q rails.
  function automatic logic readback_bad(input logic [WIDTH-1:0] d,
                                        input logic [WIDTH-1:0] q,
                                        input logic [WIDTH-1:0] nq);
    return (q != d) || (nq != ~d);
  endfunction

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] latch_d_r, latch_d_s;
  logic [IDW-1:0]   grant_id_r, grant_id_s;
  logic [IDW-1:0]   rr_ptr_r, rr_ptr_s;
  logic [NREQ-1:0]  ack_r, ack_s;
  logic             latch_en_r, latch_en_s;
  logic             busy_r, busy_s;
  logic             err_r, err_s;
  logic             err_sticky_r, err_sticky_s;
  logic             win_found_s;
  logic [IDW-1:0]   win_id_s;
  logic [IDW:0]     cand_s;

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
      if (cand_s >= NREQ_W) begin
        cand_s = cand_s - NREQ_W;
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req[cand_s[IDW-1:0]]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s[IDW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output logic; outputs are precomputed so they leave flops.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    latch_d_s    = latch_d_r;
    grant_id_s   = grant_id_r;
    rr_ptr_s     = rr_ptr_r;
    ack_s        = '0;
    latch_en_s   = 1'b0;
    err_s        = 1'b0;
    err_sticky_s = err_sticky_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          latch_d_s  = data_in[win_id_s*WIDTH +: WIDTH];
          grant_id_s = win_id_s;
          cnt_s      = '0;
          state_s    = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          cnt_s      = '0;
          latch_en_s = 1'b1;
          state_s    = ENABLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ENABLE: begin
        if (cnt_r == EN_LAST) begin
          cnt_s   = '0;
          state_s = HOLD;
        end else begin
          cnt_s      = cnt_r + CW'(1);
          latch_en_s = 1'b1;
        end
      end
      HOLD: begin
        // Readback is registered on entry to CHECK so err lines up with ack.
        if (cnt_r == HOLD_LAST) begin
          cnt_s             = '0;
          ack_s[grant_id_r] = 1'b1;
          err_s             = readback_bad(latch_d_r, latch_q, latch_nq);
          err_sticky_s      = err_sticky_r | err_s;
          state_s           = CHECK;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      CHECK: begin
        if (grant_id_r == ID_LAST) begin
          rr_ptr_s = '0;
        end else begin
          rr_ptr_s = grant_id_r + IDW'(1);
        end
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset abandons any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      latch_d_r    <= '0;
      grant_id_r   <= '0;
      rr_ptr_r     <= '0;
      ack_r        <= '0;
      latch_en_r   <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      latch_d_r    <= latch_d_s;
      grant_id_r   <= grant_id_s;
      rr_ptr_r     <= rr_ptr_s;
      ack_r        <= ack_s;
      latch_en_r   <= latch_en_s;
      busy_r       <= busy_s;
      err_r        <= err_s;
      err_sticky_r <= err_sticky_s;
    end
  end

  assign ack        = ack_r;
  assign latch_en   = latch_en_r;
  assign latch_d    = latch_d_r;
  assign busy       = busy_r;
  assign grant_id   = grant_id_r;
  assign err        = err_r;
  assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Self-checking bench for latch_write_arbiter: vector table, directed corner
// cases, and randomized traffic against a transaction-level reference model.
module tb_latch_write_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int S = 1, E = 2, H = 1;
  localparam int ACK_OFS = S + E + H + 1;
  localparam int PERIOD  = S + E + H + 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data_in = '0;
  logic [NREQ-1:0]       ack;
  logic                  latch_en;
  logic [WIDTH-1:0]      latch_d, latch_q, latch_nq;
  logic                  busy;
  logic [1:0]            grant_id;
  logic                  err, err_sticky;

  logic                  fq_en = 1'b0;
  logic [WIDTH-1:0]      fq = '0;
  logic                  nq_stuck = 1'b0;
  logic [WIDTH-1:0]      q_store;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  latch_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .SETUP_CYCLES(S),
                        .EN_CYCLES(E), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
    .latch_en(latch_en), .latch_d(latch_d), .latch_q(latch_q),
    .latch_nq(latch_nq), .busy(busy), .grant_id(grant_id), .err(err),
    .err_sticky(err_sticky));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gated D latch bank with optional stuck faults on the Q and not_Q rails.
  always_latch begin
    if (latch_en) q_store <= latch_d;
  end
  assign latch_q  = fq_en ? fq : q_store;
  assign latch_nq = nq_stuck ? latch_q : ~q_store;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete write: raise requests, follow it to ack, check timing and result.
  task automatic run_write(input string name, input logic [NREQ-1:0] r,
                           input logic [NREQ*WIDTH-1:0] dat, input int exp_g,
                           input logic [WIDTH-1:0] exp_d, input logic exp_err,
                           input bit tog);
    int en_cnt, ack_n;
    bit d_ok, got;
    en_cnt = 0; ack_n = -1; d_ok = 1'b1; got = 1'b0;
    @(negedge clk);
    req = r;
    data_in = dat;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (latch_en) begin
        en_cnt++;
        if (tog) data_in[WIDTH-1:0] = ~data_in[WIDTH-1:0];
      end
      if (busy && latch_d !== exp_d) d_ok = 1'b0;
      if (ack != '0) begin
        got = 1'b1;
        ack_n = c;
        chk({name, "_ackvec"}, 32'(ack), 32'(1 << exp_g));
        chk({name, "_grant"}, 32'(grant_id), 32'(exp_g));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_busy_check"}, 32'(busy), 32'd1);
      end
    end
    req = '0;
    chk({name, "_ack_cycle"}, 32'(ack_n), 32'(ACK_OFS));
    chk({name, "_en_cycles"}, 32'(en_cnt), 32'(E));
    chk({name, "_d_stable"}, 32'(d_ok), 32'd1);
    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_ack"}, 32'(ack), 32'd0);
  endtask

  typedef struct {
    logic [NREQ-1:0]       r;
    logic [NREQ*WIDTH-1:0] dat;
    int                    g;
    logic [WIDTH-1:0]      d;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int g, last, a_edge, g_edge, next_free, model_rr, exp_g, idx;
    bit got, seen, found;
    logic [WIDTH-1:0] exp_d;
    logic [NREQ-1:0] ack_seen;

    // Grants follow round-robin from rr_ptr=0 after reset.
    vecs[0] = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
    vecs[1] = '{4'b0011, 32'h1122_3344, 0, 8'h44};
    vecs[2] = '{4'b1001, 32'hC35A_1234, 3, 8'hC3};
    vecs[3] = '{4'b0110, 32'h0102_7E04, 1, 8'h7E};
    vecs[4] = '{4'b0001, 32'h0000_0081, 0, 8'h81};
    vecs[5] = '{4'b1110, 32'h9988_3C66, 1, 8'h3C};

    repeat (2) @(negedge clk);
    chk("rst_latch_en", 32'(latch_en), 32'd0);
    chk("rst_latch_d", 32'(latch_d), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++)
      run_write($sformatf("vec%0d", v), vecs[v].r, vecs[v].dat, vecs[v].g, vecs[v].d, 1'b0, 1'b0);

    run_write("toggle", 4'b0001, 32'h0000_005C, 0, 8'h5C, 1'b0, 1'b1);

    fq_en = 1'b1; fq = 8'h00;
    run_write("qfault", 4'b0010, 32'h0000_FF00, 1, 8'hFF, 1'b1, 1'b0);
    fq_en = 1'b0;
    chk("qfault_sticky", 32'(err_sticky), 32'd1);
    run_write("after_fault", 4'b0001, 32'h0000_0037, 0, 8'h37, 1'b0, 1'b0);
    chk("sticky_holds", 32'(err_sticky), 32'd1);
    nq_stuck = 1'b1;
    run_write("nqfault", 4'b1000, 32'h5A00_0000, 3, 8'h5A, 1'b1, 1'b0);
    nq_stuck = 1'b0;

    // Reset during ENABLE abandons the write.
    @(negedge clk);
    req = 4'b1000; data_in = 32'hE700_0000;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (latch_en) seen = 1'b1;
    end
    chk("midrst_en_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_en", 32'(latch_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_d", 32'(latch_d), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_sticky", 32'(err_sticky), 32'd0);
    rst = 1'b0; req = '0;
    run_write("post_rst", 4'b1010, 32'h3300_7700, 1, 8'h77, 1'b0, 1'b0);

    // All four requesters contend; each re-raises right after its ack.
    do_reset();
    req = 4'b1111; data_in = 32'h4433_2211;
    last = 0;
    for (int a = 0; a < 5; a++) begin
      got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        @(negedge clk);
        if (ack != '0) got = 1'b1;
      end
      chk("rr_ack_seen", 32'(got), 32'd1);
      g = -1;
      for (int i = 0; i < NREQ; i++) if (ack[i]) g = i;
      chk("rr_order", 32'(g), 32'(a % NREQ));
      if (a > 0) chk("rr_gap", 32'(cyc - last), 32'(PERIOD));
      last = cyc;
      if (g >= 0) req[g] = 1'b0;
      @(negedge clk);
      if (g >= 0) req[g] = 1'b1;
    end

    // Random traffic against a transaction-level model.
    do_reset();
    data_in = '0;
    a_edge = -10; g_edge = -10; next_free = 0; model_rr = 0; exp_g = 0; exp_d = '0;
    for (int j = 0; j < 3000; j++) begin
      @(posedge clk);
      if (j >= next_free && req != '0) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          idx = (model_rr + k) % NREQ;
          if (!found && req[idx]) begin
            found = 1'b1;
            exp_g = idx;
          end
        end
        exp_d = data_in[exp_g*WIDTH +: WIDTH];
        g_edge = j;
        a_edge = j + ACK_OFS - 1;
        next_free = j + PERIOD;
        model_rr = (exp_g + 1) % NREQ;
      end
      @(negedge clk);
      chk("rnd_busy", 32'(busy), 32'((j >= g_edge && j <= a_edge) ? 1 : 0));
      if (j == a_edge) begin
        chk("rnd_ack", 32'(ack), 32'(1 << exp_g));
        chk("rnd_d", 32'(latch_d), 32'(exp_d));
        chk("rnd_err", 32'(err), 32'd0);
      end else begin
        chk("rnd_noack", 32'(ack), 32'd0);
      end
      ack_seen = ack;
      for (int i = 0; i < NREQ; i++) begin
        if (ack_seen[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          data_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          data_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
    end
    chk("rnd_sticky", 32'(err_sticky), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
